// File: rtl/rx_fifo.sv
// Purpose: FWFT receive buffer behind Rx_path, storing {err, data} per frame, with a sticky overflow flag and a saturating error count.
// Latency: a frame strobed at edge N is on rd_data after edge N; a pop exposes the next entry after the popping edge.
// Backpressure: none upstream (Rx_path cannot stall); a strobe while full and not popping is dropped and sets overflow.
//
// Ports:
//   clk, reset (async, active-low)
//   rx_valid/rx_err/rx_data : one-cycle frame strobe with error flag and word from Rx_path
//   rd_en                   : consumer pop request; ignored while empty
//   rd_data/rd_err          : head entry, forced to 0 while empty
//   empty/full/count        : occupancy, all derived from the registered count
//   overflow/err_count/clr  : sticky drop flag, saturating errored-frame count, synchronous clear of both
module rx_fifo #(
  parameter int WIDTH_SIZE = 16,
  parameter int DEPTH      = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rx_valid,
  input  logic                       rx_err,
  input  logic [WIDTH_SIZE-1:0]      rx_data,
  input  logic                       rd_en,
  output logic [WIDTH_SIZE-1:0]      rd_data,
  output logic                       rd_err,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [7:0]                 err_count,
  input  logic                       clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Each entry is {err, data}.
  logic [WIDTH_SIZE:0] mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [CW-1:0]       count_q;
  logic                overflow_q;
  logic [7:0]          err_count_q;

  logic pop;
  logic wr;
  logic drop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;

  // A pop frees the slot in the same cycle, so a full FIFO still accepts a
  // strobe when the consumer pops. When empty there is no bypass: the pop is
  // ignored and the incoming word becomes the new head.
  assign pop  = rd_en & ~empty;
  assign wr   = rx_valid & (~full | pop);
  assign drop = rx_valid & full & ~pop;

  // Storage is deliberately not reset; the occupancy count guards reads.
  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wr_ptr] <= {rx_err, rx_data};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally.
      if (wr) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Error accounting includes dropped frames; clr wins over set/increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q  <= 1'b0;
      err_count_q <= 8'd0;
    end else if (clr) begin
      overflow_q  <= 1'b0;
      err_count_q <= 8'd0;
    end else begin
      if (drop) begin
        overflow_q <= 1'b1;
      end
      if (rx_valid && rx_err && (err_count_q != 8'hFF)) begin
        err_count_q <= err_count_q + 8'd1;
      end
    end
  end

  assign overflow  = overflow_q;
  assign err_count = err_count_q;

  // Head entry is gated to zero while empty so stale array contents never leak.
  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    if (!empty) begin
      rd_data = mem[rd_ptr][WIDTH_SIZE-1:0];
      rd_err  = mem[rd_ptr][WIDTH_SIZE];
    end
  end

endmodule

// File: tb/tb_rx_fifo.sv
// Bench for rx_fifo: directed vector table, hand-written corner sequences, and
// randomized traffic against a queue-based reference model.
module tb_rx_fifo;

  localparam int W = 16;
  localparam int D = 8;

  logic           clk;
  logic           reset;
  logic           rx_valid;
  logic           rx_err;
  logic [W-1:0]   rx_data;
  logic           rd_en;
  logic           clr;
  logic [W-1:0]   rd_data;
  logic           rd_err;
  logic           empty;
  logic           full;
  logic [3:0]     count;
  logic           overflow;
  logic [7:0]     err_count;

  rx_fifo #(.WIDTH_SIZE(W), .DEPTH(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_valid  (rx_valid),
    .rx_err    (rx_err),
    .rx_data   (rx_data),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_err    (rd_err),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .overflow  (overflow),
    .err_count (err_count),
    .clr       (clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a queue of {err, data} plus flag/counter state.
  logic [W:0] mq[$];
  bit         m_ovf;
  int         m_ec;

  typedef struct {
    bit         v;
    bit         e;
    logic [W-1:0] d;
    bit         rd;
    bit         c;
    int         ecount;
    logic [W-1:0] edata;
    bit         eerr;
    bit         eovf;
    int         eec;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_ec  = 0;
  endtask

  task automatic model_step(input bit v, input bit e, input logic [W-1:0] d,
                            input bit rd, input bit c);
    bit do_pop;
    bit was_full;
    do_pop   = rd && (mq.size() > 0);
    was_full = (mq.size() == D);
    if (do_pop) void'(mq.pop_front());
    if (v) begin
      if (!was_full || do_pop) mq.push_back({e, d});
      else m_ovf = 1'b1;
      if (e && m_ec < 255) m_ec++;
    end
    if (c) begin
      m_ovf = 1'b0;
      m_ec  = 0;
    end
  endtask

  // One clock: drive, advance the model, then release inputs 1 time unit after the edge.
  task automatic step(input bit v, input bit e, input logic [W-1:0] d,
                      input bit rd, input bit c);
    rx_valid = v;
    rx_err   = e;
    rx_data  = d;
    rd_en    = rd;
    clr      = c;
    @(posedge clk);
    model_step(v, e, d, rd, c);
    #1;
    rx_valid = 1'b0;
    rx_err   = 1'b0;
    rx_data  = '0;
    rd_en    = 1'b0;
    clr      = 1'b0;
  endtask

  task automatic check_model(input string tag);
    logic [W-1:0] hd;
    bit           he;
    hd = '0;
    he = 1'b0;
    if (mq.size() > 0) begin
      hd = mq[0][W-1:0];
      he = mq[0][W];
    end
    chk({tag, ".count"},     32'(count),     32'(mq.size()));
    chk({tag, ".empty"},     32'(empty),     32'(mq.size() == 0));
    chk({tag, ".full"},      32'(full),      32'(mq.size() == D));
    chk({tag, ".rd_data"},   32'(rd_data),   32'(hd));
    chk({tag, ".rd_err"},    32'(rd_err),    32'(he));
    chk({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
    chk({tag, ".err_count"}, 32'(err_count), 32'(m_ec));
  endtask

  function automatic vec_t mk(bit v, bit e, logic [W-1:0] d, bit rd, bit c,
                              int ecount, logic [W-1:0] edata, bit eerr, bit eovf, int eec);
    vec_t t;
    t = '{v: v, e: e, d: d, rd: rd, c: c, ecount: ecount, edata: edata,
          eerr: eerr, eovf: eovf, eec: eec};
    return t;
  endfunction

  initial begin
    logic [W-1:0] last;

    // Directed table: FWFT order, then fill / drop / drain.
    tbl.push_back(mk(1, 0, 16'h5555, 0, 0, 1, 16'h5555, 0, 0, 0));
    tbl.push_back(mk(1, 1, 16'h5D5D, 0, 0, 2, 16'h5555, 0, 0, 1));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 16'h5D5D, 1, 0, 1));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 1));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 1, 0, 16'h0000, 0, 0, 0));
    for (int k = 1; k <= D; k++)
      tbl.push_back(mk(1, 0, 16'(k), 0, 0, k, 16'h0001, 0, 0, 0));
    tbl.push_back(mk(1, 1, 16'h0009, 0, 0, D, 16'h0001, 0, 1, 1));
    for (int k = 1; k <= D; k++)
      tbl.push_back(mk(0, 0, 16'h0000, 1, 0, D - k, (k < D) ? 16'(k + 1) : 16'h0000, 0, 1, 1));

    rx_valid = 1'b0;
    rx_err   = 1'b0;
    rx_data  = '0;
    rd_en    = 1'b0;
    clr      = 1'b0;
    reset    = 1'b0;
    model_reset();
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;

    chk("reset.empty",     32'(empty),     32'd1);
    chk("reset.full",      32'(full),      32'd0);
    chk("reset.count",     32'(count),     32'd0);
    chk("reset.rd_data",   32'(rd_data),   32'd0);
    chk("reset.overflow",  32'(overflow),  32'd0);
    chk("reset.err_count", 32'(err_count), 32'd0);

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].e, tbl[i].d, tbl[i].rd, tbl[i].c);
      chk($sformatf("vec%0d.count", i),     32'(count),     32'(tbl[i].ecount));
      chk($sformatf("vec%0d.empty", i),     32'(empty),     32'(tbl[i].ecount == 0));
      chk($sformatf("vec%0d.full", i),      32'(full),      32'(tbl[i].ecount == D));
      chk($sformatf("vec%0d.rd_data", i),   32'(rd_data),   32'(tbl[i].edata));
      chk($sformatf("vec%0d.rd_err", i),    32'(rd_err),    32'(tbl[i].eerr));
      chk($sformatf("vec%0d.overflow", i),  32'(overflow),  32'(tbl[i].eovf));
      chk($sformatf("vec%0d.err_count", i), 32'(err_count), 32'(tbl[i].eec));
    end

    // Simultaneous write and pop while full: no drop, new word read last.
    step(0, 0, 0, 0, 1);
    for (int k = 0; k < D; k++) step(1, 0, 16'h0010 + 16'(k), 0, 0);
    step(1, 0, 16'h0018, 1, 0);
    chk("wrpop_full.count",    32'(count),    32'd8);
    chk("wrpop_full.overflow", 32'(overflow), 32'd0);
    chk("wrpop_full.head",     32'(rd_data),  32'h0011);
    last = '0;
    for (int k = 0; k < D; k++) begin
      last = rd_data;
      step(0, 0, 0, 1, 0);
      check_model($sformatf("drain%0d", k));
    end
    chk("wrpop_full.last", 32'(last), 32'h0018);

    // Simultaneous write and pop while empty: write wins, no bypass.
    step(1, 0, 16'h0077, 1, 0);
    chk("wrpop_empty.count",   32'(count),   32'd1);
    chk("wrpop_empty.rd_data", 32'(rd_data), 32'h0077);
    step(0, 0, 0, 1, 0);
    check_model("wrpop_empty.pop");

    // Error count saturation.
    for (int k = 0; k < 300; k++) step(1, 1, 16'($urandom), 1, 0);
    chk("sat.err_count", 32'(err_count), 32'd255);
    check_model("sat");
    step(0, 0, 0, 1, 0);
    for (int k = 0; k < D; k++) step(1, 0, 16'h0100 + 16'(k), 0, 0);
    // clr together with an errored strobe that would be dropped.
    step(1, 1, 16'hDEAD, 0, 1);
    chk("clr.err_count", 32'(err_count), 32'd0);
    chk("clr.overflow",  32'(overflow),  32'd0);
    chk("clr.count",     32'(count),     32'd8);
    for (int k = 0; k < D; k++) step(0, 0, 0, 1, 0);
    check_model("clr.drained");

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0, 16'($urandom),
           $urandom_range(0, 2) == 0, $urandom_range(0, 40) == 0);
      check_model($sformatf("rnd%0d", k));
    end

    // Reset mid-operation with wrapped pointers and 3 stored entries.
    while (mq.size() > 0) step(0, 0, 0, 1, 0);
    for (int k = 0; k < 11; k++) step(1, 0, 16'h0200 + 16'(k), 1, 0);
    step(0, 0, 0, 1, 0);
    for (int k = 0; k < 3; k++) step(1, 0, 16'h0300 + 16'(k), 0, 0);
    chk("prereset.count", 32'(count), 32'd3);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset.empty",   32'(empty),   32'd1);
    chk("async_reset.count",   32'(count),   32'd0);
    chk("async_reset.rd_data", 32'(rd_data), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(1, 0, 16'hABCD, 0, 0);
    chk("post_reset.rd_data", 32'(rd_data), 32'hABCD);
    check_model("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_fifo.md
# rx_fifo

Receive-side buffer that sits directly downstream of `Rx_path` in the UART. It captures every frame `Rx_path` reports through its one-cycle `valid` pulse, together with the frame's `err` flag. It stores them in a first-word-fall-through FIFO and presents them to the consumer through a pop interface. It also keeps a sticky overflow flag and a saturating count of errored frames so software can judge link quality.

## Interface
Parameters:
- `WIDTH_SIZE`, 16, data word width; must match `Rx_path`.
- `DEPTH`, 8, number of entries; power of two, ≥ 2.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rx_valid`  in  1  one-cycle frame strobe; driven by `Rx_path.valid`.
- `rx_err`  in  1  frame error flag (parity/stop), qualified by `rx_valid`; driven by `Rx_path.err`.
- `rx_data`  in  `WIDTH_SIZE`  received word, qualified by `rx_valid`; driven by `Rx_path.data`.
- `rd_en`  in  1  pop request from the consumer.
- `rd_data`  out  `WIDTH_SIZE`  head entry data.
- `rd_err`  out  1  head entry error flag.
- `empty`  out  1  FIFO holds no entries.
- `full`  out  1  FIFO holds `DEPTH` entries.
- `count`  out  `$clog2(DEPTH)+1`  number of stored entries, 0..`DEPTH`.
- `overflow`  out  1  sticky: a frame was dropped because the FIFO was full.
- `err_count`  out  8  saturating count of frames received with `rx_err`=1.
- `clr`  in  1  synchronous clear of `overflow` and `err_count`.

## Operation
- **Storage:** `DEPTH` × (`WIDTH_SIZE`+1) array; each entry holds {err, data}. Write pointer and read pointer are each `$clog2(DEPTH)` bits and wrap modulo `DEPTH`. The registered `count` is the source of `empty` (`count`==0) and `full` (`count`==`DEPTH`).
- **Write:** on `rx_valid`=1 the {`rx_err`, `rx_data`} pair is written at the write pointer and the write pointer advances. This happens if not full, or if full and a pop occurs in the same cycle.
- **Drop:** `rx_valid`=1 while full with no pop drops the frame. Pointers and `count` are unchanged, and `overflow` is set.
- **Read (FWFT):** while not empty, `rd_data`/`rd_err` combinationally show the entry at the read pointer. `rd_en`=1 with not empty advances the read pointer at the clock edge. `rd_en` while empty is ignored, with no underflow flag.
- **Output gating:** while empty, `rd_data`=0 and `rd_err`=0.
- **Count update:** `count` += 1 on write-only, −= 1 on pop-only, and is unchanged on write+pop or neither.
- **Write and pop when empty:** the write is accepted, the pop is ignored, and `count` becomes 1. There is no bypass: the word appears on `rd_data` the next cycle.
- **Error count:** `err_count` increments on every `rx_valid`&`rx_err`, including dropped frames, and saturates at 255.
- **Clear:** `clr`=1 forces `overflow`=0 and `err_count`=0. It takes priority over any set or increment in the same cycle. `clr` does not touch FIFO contents.
- **No FSM:** state is the pointers, `count`, `overflow`, `err_count` and the array.

## Timing
- **Reset:** `reset` low asynchronously sets both pointers to 0, `count`=0, `empty`=1, `full`=0, `overflow`=0, `err_count`=0, `rd_data`=0, `rd_err`=0. The array itself is not reset. Reset asserted mid-operation discards all stored frames immediately.
- **Write latency:** a frame strobed at edge N is visible on `rd_data` after edge N, with `empty` deasserted in the same cycle; latency is 1 cycle.
- **Pop:** the next entry (or 0 with `empty`=1) appears after the popping edge.
- **Flags:** `overflow` and `err_count` update on the edge that samples the event.
- **Throughput:** one write and one pop per cycle are sustained. `Rx_path` strobes at most once per frame, so back-to-back strobes are legal but need not be exercised beyond the tests below.

## Test plan
- **Reset values:** hold `reset` low 5 cycles, release. Expect `empty`=1, `count`=0, `rd_data`=0, `overflow`=0, `err_count`=0.
- **FWFT order:** strobe 0x5555 (`rx_err`=0), then 0x5D5D (`rx_err`=1).
  - Expect `rd_data`=0x5555, `rd_err`=0, `count`=2, `err_count`=1.
  - After one `rd_en`: 0x5D5D with `rd_err`=1.
  - After a second `rd_en`: `empty`=1 and `rd_data`=0.
- **Full and drop:** write `DEPTH`=8 words 0x0001..0x0008. Expect `full`=1, `count`=8.
  - Ninth strobe 0x0009 with `rx_err`=1 → `overflow`=1, `err_count`=1, `count`=8.
  - Draining yields 0x0001..0x0008 in order and never 0x0009.
- **Simultaneous write and pop:**
  - When full, a strobe plus `rd_en` in the same cycle → `count` stays 8, `overflow` stays 0, and the new word is read last.
  - When empty, the same stimulus → `count`=1.
- **Saturation and clear:** 300 errored strobes with continuous `rd_en` → `err_count`=255. Assert `clr` in the same cycle as an errored strobe → `err_count`=0, `overflow`=0.
- **Reset mid-operation, with wrap-around:** with 3 entries stored and the pointers wrapped past index 7, pulse `reset` low.
  - Expect `empty`=1 immediately, without waiting for a clock edge.
  - A subsequent write of 0xABCD reads back as 0xABCD.
